issue_ctrl: RTL and testbench

In-order issue controller between the instruction fetcher and the out-of-order back end. It buffers fetched instructions in a small queue and presents the head to the combinational instruction decoder. It routes each decoded instruction to the ROB plus either the reservation station (RS) or the load/store buffer (LSB), stalling on back-end full flags. It also allows at most one unresolved JALR in flight and flushes on rollback.

---
 rtl/issue_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_issue_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// In-order issue controller: buffers fetched instructions, presents the queue head
// to the decoder, and routes decoded instructions to the ROB plus RS or LSB.
module issue_ctrl #(
    parameter int QLOG    = 3,
    parameter int OPNUM_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush,
    input  logic               jalr_done,
    input  logic               fetch_valid,
    input  logic [31:0]        fetch_inst,
    input  logic [31:0]        fetch_pc,
    output logic               queue_full,
    output logic [31:0]        dec_inst,
    input  logic [OPNUM_W-1:0] dec_opnum,
    input  logic               dec_is_ls,
    input  logic               dec_is_jump,
    input  logic [4:0]         dec_rd,
    input  logic [4:0]         dec_rs1,
    input  logic [4:0]         dec_rs2,
    input  logic [31:0]        dec_imm,
    input  logic               rob_full,
    input  logic               rs_full,
    input  logic               lsb_full,
    output logic               rob_issue,
    output logic               rs_issue,
    output logic               lsb_issue,
    output logic [OPNUM_W-1:0] iss_opnum,
    output logic [4:0]         iss_rd,
    output logic [4:0]         iss_rs1,
    output logic [4:0]         iss_rs2,
    output logic [31:0]        iss_imm,
    output logic [31:0]        iss_pc,
    output logic               iss_is_jump
);

    localparam int DEPTH = 1 << QLOG;
    localparam logic [QLOG:0] FULL_CNT = {1'b1, {QLOG{1'b0}}};

    typedef enum logic [0:0] {
        NORMAL    = 1'b0,
        WAIT_JALR = 1'b1
    } state_t;

    state_t state, next_state;

    logic [31:0]     q_inst [DEPTH];
    logic [31:0]     q_pc   [DEPTH];
    logic [QLOG-1:0] head, tail;
    logic [QLOG:0]   count;
    logic            q_empty;

    logic do_push, do_pop;
    logic issue_rs, issue_ls, issue_any, head_is_jalr;
    logic rob_q, rs_q, lsb_q;

    assign q_empty    = (count == '0);
    assign queue_full = (count == FULL_CNT);
    assign dec_inst   = q_empty ? 32'h0 : q_inst[head];

    // A push offered while full is dropped even if the head pops this cycle.
    assign do_push = rdy && !flush && fetch_valid && !queue_full;

    assign head_is_jalr = dec_is_jump && (dec_inst[6:0] == 7'b1100111);
    assign issue_any    = issue_rs || issue_ls;

    always_comb begin
        do_pop     = 1'b0;
        issue_rs   = 1'b0;
        issue_ls   = 1'b0;
        next_state = state;
        if (rdy && !flush && state == NORMAL && !q_empty) begin
            if (dec_opnum == '0) begin
                do_pop = 1'b1;
            end else if (dec_is_ls) begin
                if (!rob_full && !lsb_full) begin
                    do_pop   = 1'b1;
                    issue_ls = 1'b1;
                end
            end else begin
                if (!rob_full && !rs_full) begin
                    do_pop   = 1'b1;
                    issue_rs = 1'b1;
                end
            end
        end
        case (state)
            NORMAL: begin
                if (issue_any && head_is_jalr)
                    next_state = WAIT_JALR;
            end
            WAIT_JALR: begin
                if (jalr_done)
                    next_state = NORMAL;
            end
            default: next_state = NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= NORMAL;
        else if (flush)
            state <= NORMAL;
        else if (rdy)
            state <= next_state;
    end

    // Storage needs no reset: only entries between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_inst[tail] <= fetch_inst;
            q_pc[tail]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                tail <= tail + QLOG'(1);
            if (do_pop)
                head <= head + QLOG'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (QLOG+1)'(1);
                2'b01:   count <= count - (QLOG+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Strobes are masked while rdy is low so the back end never consumes them then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rob_q <= 1'b0;
            rs_q  <= 1'b0;
            lsb_q <= 1'b0;
        end else if (flush) begin
            rob_q <= 1'b0;
            rs_q  <= 1'b0;
            lsb_q <= 1'b0;
        end else if (rdy) begin
            rob_q <= issue_any;
            rs_q  <= issue_rs;
            lsb_q <= issue_ls;
        end
    end

    assign rob_issue = rob_q && rdy;
    assign rs_issue  = rs_q && rdy;
    assign lsb_issue = lsb_q && rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_opnum   <= '0;
            iss_rd      <= '0;
            iss_rs1     <= '0;
            iss_rs2     <= '0;
            iss_imm     <= '0;
            iss_pc      <= '0;
            iss_is_jump <= 1'b0;
        end else if (issue_any) begin
            iss_opnum   <= dec_opnum;
            iss_rd      <= dec_rd;
            iss_rs1     <= dec_rs1;
            iss_rs2     <= dec_rs2;
            iss_imm     <= dec_imm;
            iss_pc      <= q_pc[head];
            iss_is_jump <= dec_is_jump;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl; a small RV32I decoder model sits on dec_inst
// and every expected value below is worked out by hand.
module tb_issue_ctrl;

    localparam logic [5:0] OP_ADDI = 6'd13;
    localparam logic [5:0] OP_LW   = 6'd3;
    localparam logic [5:0] OP_JALR = 6'd21;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, jalr_done, fetch_valid;
    logic [31:0] fetch_inst, fetch_pc;
    logic        queue_full;
    logic [31:0] dec_inst;
    logic [5:0]  dec_opnum;
    logic        dec_is_ls, dec_is_jump;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] dec_imm;
    logic        rob_full, rs_full, lsb_full;
    logic        rob_issue, rs_issue, lsb_issue;
    logic [5:0]  iss_opnum;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic [31:0] iss_imm, iss_pc;
    logic        iss_is_jump;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    issue_ctrl #(.QLOG(3), .OPNUM_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .jalr_done(jalr_done),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
        .queue_full(queue_full), .dec_inst(dec_inst),
        .dec_opnum(dec_opnum), .dec_is_ls(dec_is_ls), .dec_is_jump(dec_is_jump),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_issue(rob_issue), .rs_issue(rs_issue), .lsb_issue(lsb_issue),
        .iss_opnum(iss_opnum), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_is_jump(iss_is_jump)
    );

    // Decoder model: ADDI, LW and JALR are recognised, everything else is opnum 0.
    always_comb begin
        dec_opnum   = '0;
        dec_is_ls   = 1'b0;
        dec_is_jump = 1'b0;
        dec_rd      = dec_inst[11:7];
        dec_rs1     = dec_inst[19:15];
        dec_rs2     = dec_inst[24:20];
        dec_imm     = {{20{dec_inst[31]}}, dec_inst[31:20]};
        case (dec_inst[6:0])
            7'b0010011: if (dec_inst[14:12] == 3'b000) dec_opnum = OP_ADDI;
            7'b0000011: if (dec_inst[14:12] == 3'b010) begin
                dec_opnum = OP_LW;
                dec_is_ls = 1'b1;
            end
            7'b1100111: begin
                dec_opnum   = OP_JALR;
                dec_is_jump = 1'b1;
            end
            default: ;
        endcase
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fv, input logic [31:0] inst, input logic [31:0] pc);
        fetch_valid = fv;
        fetch_inst  = inst;
        fetch_pc    = pc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkStrobes(input string tag, input logic rob_e, input logic rs_e, input logic lsb_e);
        checkOutput({tag, "_rob"}, 32'(rob_issue), 32'(rob_e));
        checkOutput({tag, "_rs"},  32'(rs_issue),  32'(rs_e));
        checkOutput({tag, "_lsb"}, 32'(lsb_issue), 32'(lsb_e));
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; jalr_done = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0);
        cyc();
        cyc();
        checkStrobes("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset_qfull", 32'(queue_full), 32'd0);
        checkOutput("reset_dec_inst", dec_inst, 32'h0);
        checkOutput("reset_iss_pc", iss_pc, 32'h0);
        checkOutput("reset_iss_opnum", 32'(iss_opnum), 32'd0);
        rst = 1'b0;

        $display("[TB] addi latency");
        applyStimulus(1'b1, 32'h00500093, 32'h0);
        cyc();
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("addi_head", dec_inst, 32'h00500093);
        checkStrobes("addi_n1", 1'b0, 1'b0, 1'b0);
        cyc();
        checkStrobes("addi_n2", 1'b1, 1'b1, 1'b0);
        checkOutput("addi_opnum", 32'(iss_opnum), 32'(OP_ADDI));
        checkOutput("addi_rd", 32'(iss_rd), 32'd1);
        checkOutput("addi_imm", iss_imm, 32'd5);
        checkOutput("addi_pc", iss_pc, 32'h0);
        cyc();
        checkStrobes("addi_n3", 1'b0, 1'b0, 1'b0);
        checkOutput("addi_empty", dec_inst, 32'h0);

        $display("[TB] load stalled on lsb_full");
        lsb_full = 1'b1;
        applyStimulus(1'b1, 32'h0000A103, 32'h4);
        cyc();
        applyStimulus(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkStrobes($sformatf("lw_stall%0d", i), 1'b0, 1'b0, 1'b0);
            if (i < 2) cyc();
        end
        lsb_full = 1'b0;
        cyc();
        checkStrobes("lw_issue", 1'b1, 1'b0, 1'b1);
        checkOutput("lw_opnum", 32'(iss_opnum), 32'(OP_LW));
        checkOutput("lw_rd", 32'(iss_rd), 32'd2);
        checkOutput("lw_rs1", 32'(iss_rs1), 32'd1);
        checkOutput("lw_pc", iss_pc, 32'h4);
        cyc();
        checkStrobes("lw_after", 1'b0, 1'b0, 1'b0);

        $display("[TB] fill queue under rob_full");
        rob_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 32'h00000093 | (i << 20), 32'h100 + i * 4);
            cyc();
            checkOutput($sformatf("fill_qfull%0d", i), 32'(queue_full), (i >= 7) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkStrobes("fill_blocked", 1'b0, 1'b0, 1'b0);
        checkOutput("fill_head", dec_inst, 32'h00000093);
        rob_full = 1'b0;
        for (int j = 0; j < 8; j++) begin
            cyc();
            checkStrobes($sformatf("drain%0d", j), 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("drain_imm%0d", j), iss_imm, 32'(j));
            checkOutput($sformatf("drain_pc%0d", j), iss_pc, 32'h100 + j * 4);
            if (j == 0) checkOutput("drain_qfull", 32'(queue_full), 32'd0);
        end
        cyc();
        checkStrobes("drain_done", 1'b0, 1'b0, 1'b0);
        checkOutput("drain_empty", dec_inst, 32'h0);

        $display("[TB] jalr blocks issue");
        applyStimulus(1'b1, 32'h000080E7, 32'h200);
        cyc();
        applyStimulus(1'b1, 32'h00700113, 32'h204);
        cyc();
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkStrobes("jalr_issue", 1'b1, 1'b1, 1'b0);
        checkOutput("jalr_opnum", 32'(iss_opnum), 32'(OP_JALR));
        checkOutput("jalr_is_jump", 32'(iss_is_jump), 32'd1);
        checkOutput("jalr_pc", iss_pc, 32'h200);
        checkOutput("jalr_next_head", dec_inst, 32'h00700113);
        cyc();
        checkStrobes("jalr_wait1", 1'b0, 1'b0, 1'b0);
        cyc();
        checkStrobes("jalr_wait2", 1'b0, 1'b0, 1'b0);
        jalr_done = 1'b1;
        cyc();
        jalr_done = 1'b0;
        checkStrobes("jalr_done1", 1'b0, 1'b0, 1'b0);
        cyc();
        checkStrobes("jalr_done2", 1'b1, 1'b1, 1'b0);
        checkOutput("jalr_addi_rd", 32'(iss_rd), 32'd2);
        checkOutput("jalr_addi_imm", iss_imm, 32'd7);
        checkOutput("jalr_addi_is_jump", 32'(iss_is_jump), 32'd0);
        cyc();
        checkStrobes("jalr_after", 1'b0, 1'b0, 1'b0);

        $display("[TB] flush with pending jalr");
        applyStimulus(1'b1, 32'h000080E7, 32'h300);
        cyc();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 32'h00000093 | ((k + 1) << 20), 32'h304 + k * 4);
            cyc();
            if (k == 0) checkStrobes("flush_jalr", 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkStrobes("flush_held", 1'b0, 1'b0, 1'b0);
        checkOutput("flush_head", dec_inst, 32'h00100093);
        flush = 1'b1;
        applyStimulus(1'b1, 32'h00900193, 32'h3F0);
        cyc();
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("flush_empty", dec_inst, 32'h0);
        checkOutput("flush_qfull", 32'(queue_full), 32'd0);
        checkStrobes("flush_next", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00B00213, 32'h400);
        cyc();
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("flush_newhead", dec_inst, 32'h00B00213);
        cyc();
        checkStrobes("flush_resume", 1'b1, 1'b1, 1'b0);
        checkOutput("flush_resume_rd", 32'(iss_rd), 32'd4);
        checkOutput("flush_resume_imm", iss_imm, 32'd11);
        checkOutput("flush_resume_pc", iss_pc, 32'h400);
        cyc();
        checkStrobes("flush_done", 1'b0, 1'b0, 1'b0);
        checkOutput("flush_done_empty", dec_inst, 32'h0);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, 32'h00500093, 32'h500);
        cyc();
        applyStimulus(1'b1, 32'h00700113, 32'h504);
        cyc();
        applyStimulus(1'b0, 32'h0, 32'h0);
        rs_full = 1'b1;
        checkStrobes("arst_pre", 1'b1, 1'b1, 1'b0);
        checkOutput("arst_pre_pc", iss_pc, 32'h500);
        #1;
        rst = 1'b1;
        #2;
        checkStrobes("arst", 1'b0, 1'b0, 1'b0);
        checkOutput("arst_pc", iss_pc, 32'h0);
        checkOutput("arst_imm", iss_imm, 32'h0);
        checkOutput("arst_opnum", 32'(iss_opnum), 32'd0);
        checkOutput("arst_dec_inst", dec_inst, 32'h0);
        cyc();
        rst = 1'b0;
        rs_full = 1'b0;
        cyc();
        checkStrobes("arst_idle", 1'b0, 1'b0, 1'b0);

        $display("[TB] unknown opcode");
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'h600);
        cyc();
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("illegal_head", dec_inst, 32'hFFFFFFFF);
        cyc();
        checkStrobes("illegal_pop", 1'b0, 1'b0, 1'b0);
        checkOutput("illegal_empty", dec_inst, 32'h0);
        checkOutput("illegal_pc_held", iss_pc, 32'h0);

        $display("[TB] rdy low freezes stream");
        applyStimulus(1'b1, 32'h00100093, 32'h700);
        cyc();
        applyStimulus(1'b1, 32'h00200093, 32'h704);
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checkStrobes($sformatf("rdy_low%0d", i), 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("rdy_low_head%0d", i), dec_inst, 32'h00100093);
        end
        rdy = 1'b1;
        cyc();
        applyStimulus(1'b1, 32'h00300093, 32'h708);
        checkStrobes("rdy_s0", 1'b1, 1'b1, 1'b0);
        checkOutput("rdy_s0_imm", iss_imm, 32'd1);
        checkOutput("rdy_s0_pc", iss_pc, 32'h700);
        cyc();
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkStrobes("rdy_s1", 1'b1, 1'b1, 1'b0);
        checkOutput("rdy_s1_imm", iss_imm, 32'd2);
        cyc();
        checkStrobes("rdy_s2", 1'b1, 1'b1, 1'b0);
        checkOutput("rdy_s2_imm", iss_imm, 32'd3);
        checkOutput("rdy_s2_pc", iss_pc, 32'h708);
        cyc();
        checkStrobes("rdy_end", 1'b0, 1'b0, 1'b0);
        checkOutput("rdy_end_empty", dec_inst, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
